ov7670_config_sequencer: RTL and testbench

Walks the OV7670 register configuration ROM from address 0 and turns each 16-bit entry into a single register write on the SCCB master. Entry `16'hFFF0` becomes a fixed settle delay, and entry `16'hFFFF` ends the sequence. The block sits between the config ROM (1-cycle registered read) and the SCCB write master, and is started once after power-up or on demand.

---
 rtl/ov7670_config_sequencer.sv | 205 ++++++++++++++++++++
 tb/tb_ov7670_config_sequencer.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ov7670_config_sequencer.sv
// OV7670 configuration sequencer: walks the config ROM from address 0 and issues one SCCB write per entry,
// with FFF0 = settle delay and FFFF = end. Optional write timeout under OV7670_CFG_TIMEOUT_EN.
module ov7670_config_sequencer #(
  parameter int DELAY_CYCLES = 500000
`ifdef OV7670_CFG_TIMEOUT_EN
  , parameter int TIMEOUT_CYCLES = 65535
`endif
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  output logic [7:0]  rom_addr,
  input  logic [15:0] rom_data,
  output logic [7:0]  sccb_addr,
  output logic [7:0]  sccb_data,
  output logic        sccb_start,
  input  logic        sccb_ready,
  output logic        busy,
  output logic        done,
  output logic        error
);

  localparam int DLY_W = (DELAY_CYCLES > 1) ? $clog2(DELAY_CYCLES) : 1;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_FETCH    = 3'd1,
    ST_DECODE   = 3'd2,
    ST_SEND     = 3'd3,
    ST_WAIT_ACK = 3'd4,
    ST_DELAY    = 3'd5,
    ST_NEXT     = 3'd6,
    ST_DONE     = 3'd7
  } state_t;

  state_t            state_r, state_nxt_s;
  logic [7:0]        rom_addr_r, rom_addr_nxt_s;
  logic [7:0]        sccb_addr_r, sccb_addr_nxt_s;
  logic [7:0]        sccb_data_r, sccb_data_nxt_s;
  logic              sccb_start_r, sccb_start_nxt_s;
  logic              busy_r, busy_nxt_s;
  logic              done_r, done_nxt_s;
  logic [DLY_W-1:0]  dly_cnt_r, dly_cnt_nxt_s;

`ifdef OV7670_CFG_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TMO_W-1:0]  tmo_cnt_r, tmo_cnt_nxt_s;
  logic              error_r, error_nxt_s;
  logic              waiting_s;
`endif

  // Next-state and next-output logic for the sequencer FSM.
  always_comb begin
    state_nxt_s      = state_r;
    rom_addr_nxt_s   = rom_addr_r;
    sccb_addr_nxt_s  = sccb_addr_r;
    sccb_data_nxt_s  = sccb_data_r;
    sccb_start_nxt_s = 1'b0;
    busy_nxt_s       = busy_r;
    done_nxt_s       = done_r;
    dly_cnt_nxt_s    = dly_cnt_r;
`ifdef OV7670_CFG_TIMEOUT_EN
    tmo_cnt_nxt_s    = tmo_cnt_r;
    error_nxt_s      = error_r;
    waiting_s        = 1'b0;
`endif
    case (state_r)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          rom_addr_nxt_s = 8'd0;
          busy_nxt_s     = 1'b1;
          done_nxt_s     = 1'b0;
`ifdef OV7670_CFG_TIMEOUT_EN
          error_nxt_s    = 1'b0;
`endif
          state_nxt_s    = ST_FETCH;
        end else begin
          state_nxt_s    = state_r;
        end
      end
      ST_FETCH: begin
        state_nxt_s = ST_DECODE;
      end
      ST_DECODE: begin
        if (rom_data == 16'hFFFF) begin
          busy_nxt_s  = 1'b0;
          done_nxt_s  = 1'b1;
          state_nxt_s = ST_DONE;
        end else if (rom_data == 16'hFFF0) begin
          dly_cnt_nxt_s = DLY_W'(DELAY_CYCLES - 1);
          state_nxt_s   = ST_DELAY;
        end else begin
          sccb_addr_nxt_s = rom_data[15:8];
          sccb_data_nxt_s = rom_data[7:0];
`ifdef OV7670_CFG_TIMEOUT_EN
          tmo_cnt_nxt_s   = {TMO_W{1'b0}};
`endif
          state_nxt_s     = ST_SEND;
        end
      end
      ST_SEND: begin
        if (sccb_ready) begin
          sccb_start_nxt_s = 1'b1;
          state_nxt_s      = ST_WAIT_ACK;
        end else begin
`ifdef OV7670_CFG_TIMEOUT_EN
          waiting_s        = 1'b1;
`endif
          state_nxt_s      = ST_SEND;
        end
      end
      ST_WAIT_ACK: begin
        // sccb_start_r is high exactly in the first WAIT_ACK cycle, while the master still shows ready.
        if (!sccb_start_r && sccb_ready) begin
          state_nxt_s = ST_NEXT;
        end else begin
`ifdef OV7670_CFG_TIMEOUT_EN
          waiting_s   = 1'b1;
`endif
          state_nxt_s = ST_WAIT_ACK;
        end
      end
      ST_DELAY: begin
        if (dly_cnt_r == {DLY_W{1'b0}}) begin
          state_nxt_s = ST_NEXT;
        end else begin
          dly_cnt_nxt_s = dly_cnt_r - {{(DLY_W-1){1'b0}}, 1'b1};
        end
      end
      ST_NEXT: begin
        if (rom_addr_r == 8'd255) begin
          busy_nxt_s  = 1'b0;
          done_nxt_s  = 1'b1;
          state_nxt_s = ST_DONE;
        end else begin
          rom_addr_nxt_s = rom_addr_r + 8'd1;
          state_nxt_s    = ST_FETCH;
        end
      end
      default: begin
        busy_nxt_s  = 1'b0;
        state_nxt_s = ST_IDLE;
      end
    endcase
`ifdef OV7670_CFG_TIMEOUT_EN
    // SEND and WAIT_ACK share one budget; exhausting it ends the sequence with error.
    if (waiting_s) begin
      if (tmo_cnt_r == TMO_W'(TIMEOUT_CYCLES - 1)) begin
        error_nxt_s = 1'b1;
        done_nxt_s  = 1'b1;
        busy_nxt_s  = 1'b0;
        state_nxt_s = ST_DONE;
      end else begin
        tmo_cnt_nxt_s = tmo_cnt_r + {{(TMO_W-1){1'b0}}, 1'b1};
      end
    end else begin
      tmo_cnt_nxt_s = tmo_cnt_nxt_s;
    end
`endif
  end

  // State and registered-output flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= ST_IDLE;
      rom_addr_r   <= 8'd0;
      sccb_addr_r  <= 8'd0;
      sccb_data_r  <= 8'd0;
      sccb_start_r <= 1'b0;
      busy_r       <= 1'b0;
      done_r       <= 1'b0;
      dly_cnt_r    <= {DLY_W{1'b0}};
`ifdef OV7670_CFG_TIMEOUT_EN
      tmo_cnt_r    <= {TMO_W{1'b0}};
      error_r      <= 1'b0;
`endif
    end else begin
      state_r      <= state_nxt_s;
      rom_addr_r   <= rom_addr_nxt_s;
      sccb_addr_r  <= sccb_addr_nxt_s;
      sccb_data_r  <= sccb_data_nxt_s;
      sccb_start_r <= sccb_start_nxt_s;
      busy_r       <= busy_nxt_s;
      done_r       <= done_nxt_s;
      dly_cnt_r    <= dly_cnt_nxt_s;
`ifdef OV7670_CFG_TIMEOUT_EN
      tmo_cnt_r    <= tmo_cnt_nxt_s;
      error_r      <= error_nxt_s;
`endif
    end
  end

  assign rom_addr   = rom_addr_r;
  assign sccb_addr  = sccb_addr_r;
  assign sccb_data  = sccb_data_r;
  assign sccb_start = sccb_start_r;
  assign busy       = busy_r;
  assign done       = done_r;
`ifdef OV7670_CFG_TIMEOUT_EN
  assign error      = error_r;
`else
  assign error      = 1'b0;
`endif

endmodule

// File: tb/tb_ov7670_config_sequencer.sv
// Directed self-checking bench for ov7670_config_sequencer with a registered ROM model and a simple SCCB master model.
module tb_ov7670_config_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [7:0]  rom_addr;
  logic [15:0] rom_data;
  logic [7:0]  sccb_addr;
  logic [7:0]  sccb_data;
  logic        sccb_start;
  logic        sccb_ready;
  logic        busy;
  logic        done;
  logic        error;

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  ov7670_config_sequencer #(
    .DELAY_CYCLES(10)
`ifdef OV7670_CFG_TIMEOUT_EN
    , .TIMEOUT_CYCLES(50)
`endif
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .rom_addr(rom_addr), .rom_data(rom_data),
    .sccb_addr(sccb_addr), .sccb_data(sccb_data),
    .sccb_start(sccb_start), .sccb_ready(sccb_ready),
    .busy(busy), .done(done), .error(error)
  );

  // ROM with one-cycle registered read
  logic [15:0] rom_mem [0:255];
  always @(posedge clk) rom_data <= rom_mem[rom_addr];

  // SCCB master: drops ready after accepting a start, raises it again after ack_cycles
  logic mst_ready_r, mst_clr, stall, stuck_mode;
  int   ack_cycles, ack_cnt;
  assign sccb_ready = mst_ready_r & ~stall;
  always @(posedge clk) begin
    if (mst_clr) begin
      mst_ready_r <= 1'b1;
      ack_cnt     <= 0;
    end else if (sccb_start && mst_ready_r) begin
      mst_ready_r <= 1'b0;
      ack_cnt     <= ack_cycles;
    end else if (!mst_ready_r && !stuck_mode) begin
      if (ack_cnt <= 1) mst_ready_r <= 1'b1;
      else ack_cnt <= ack_cnt - 1;
    end
  end

  // Pulse monitor
  logic       mon_clr;
  int         cyc = 0;
  int         pulse_cnt = 0;
  logic [7:0] pulse_addr  [0:299];
  logic [7:0] pulse_data  [0:299];
  logic [7:0] pulse_raddr [0:299];
  int         pulse_cyc   [0:299];
  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (mon_clr) pulse_cnt <= 0;
    else if (sccb_start && pulse_cnt < 300) begin
      pulse_addr[pulse_cnt]  <= sccb_addr;
      pulse_data[pulse_cnt]  <= sccb_data;
      pulse_raddr[pulse_cnt] <= rom_addr;
      pulse_cyc[pulse_cnt]   <= cyc;
      pulse_cnt              <= pulse_cnt + 1;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic reset_models();
    mst_clr = 1'b1;
    mon_clr = 1'b1;
    @(posedge clk);
    @(negedge clk);
    #1;
    mst_clr = 1'b0;
    mon_clr = 1'b0;
  endtask

  task automatic load_term();
    for (int i = 0; i < 256; i++) rom_mem[i] = 16'hFFFF;
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int max_cycles);
    for (int n = 0; n < max_cycles; n++) begin
      @(negedge clk);
      if (done) break;
    end
    check_eq({tag, "_done_reached"}, {31'd0, done}, 32'd1);
  endtask

  int n_done;
  int rel_cyc;

  initial begin
    rst_n = 1'b0; start = 1'b0; stall = 1'b0; stuck_mode = 1'b0;
    ack_cycles = 20; mst_clr = 1'b0; mon_clr = 1'b0;
    load_term();
    reset_models();
    repeat (2) @(negedge clk);
    check_eq("rst_busy", {31'd0, busy}, 32'd0);
    check_eq("rst_done", {31'd0, done}, 32'd0);
    check_eq("rst_error", {31'd0, error}, 32'd0);
    check_eq("rst_sccb_start", {31'd0, sccb_start}, 32'd0);
    check_eq("rst_rom_addr", {24'd0, rom_addr}, 32'd0);
    check_eq("rst_sccb_addr_data", {16'd0, sccb_addr, sccb_data}, 32'd0);
    rst_n = 1'b1;

    // Write, delay, write, terminator
    load_term();
    rom_mem[0] = 16'h1280; rom_mem[1] = 16'hFFF0; rom_mem[2] = 16'h1204;
    ack_cycles = 20;
    reset_models();
    pulse_start();
    wait_done("a", 2000);
    check_eq("a_pulses", pulse_cnt, 32'd2);
    check_eq("a_w0", {16'd0, pulse_addr[0], pulse_data[0]}, 32'h1280);
    check_eq("a_w1", {16'd0, pulse_addr[1], pulse_data[1]}, 32'h1204);
    check_eq("a_gap_ge_delay", {31'd0, (pulse_cyc[1] - pulse_cyc[0]) >= 10}, 32'd1);
    check_eq("a_busy", {31'd0, busy}, 32'd0);
    check_eq("a_rom_addr", {24'd0, rom_addr}, 32'd3);

    // Terminator at address 0: done three edges after start is sampled
    load_term();
    reset_models();
    @(negedge clk);
    start = 1'b1;
    n_done = 0;
    for (int n = 1; n <= 10; n++) begin
      @(posedge clk);
      #1;
      start = 1'b0;
      if (done) begin
        n_done = n;
        break;
      end
    end
    check_eq("b_done_latency", n_done, 32'd3);
    check_eq("b_busy", {31'd0, busy}, 32'd0);
    check_eq("b_pulses", pulse_cnt, 32'd0);

    // All 256 entries are writes
    for (int i = 0; i < 256; i++) rom_mem[i] = {8'(i), 8'(i) ^ 8'h5A};
    ack_cycles = 2;
    reset_models();
    pulse_start();
    wait_done("c", 6000);
    check_eq("c_pulses", pulse_cnt, 32'd256);
    check_eq("c_w100", {16'd0, pulse_addr[100], pulse_data[100]}, 32'h643E);
    check_eq("c_w255", {16'd0, pulse_addr[255], pulse_data[255]}, 32'hFFA5);
    check_eq("c_last_rom_addr", {24'd0, pulse_raddr[255]}, 32'hFF);
    repeat (20) @(negedge clk);
    check_eq("c_no_wrap", {24'd0, rom_addr}, 32'hFF);
    check_eq("c_done_held", {31'd0, done}, 32'd1);

    // ready held low in SEND; start while busy is ignored
    load_term();
    rom_mem[0] = 16'h1280; rom_mem[1] = 16'h1204;
    ack_cycles = 20;
    stall = 1'b1;
    reset_models();
    pulse_start();
    repeat (48) @(negedge clk);
    pulse_start();
    repeat (50) @(negedge clk);
    check_eq("d_no_pulse_while_stalled", pulse_cnt, 32'd0);
    check_eq("d_busy", {31'd0, busy}, 32'd1);
    check_eq("d_rom_addr", {24'd0, rom_addr}, 32'd0);
    rel_cyc = cyc;
    stall = 1'b0;
    wait_done("d", 2000);
    check_eq("d_pulses", pulse_cnt, 32'd2);
    check_eq("d_pulse_after_release", {31'd0, pulse_cyc[0] >= rel_cyc}, 32'd1);
    check_eq("d_w0", {16'd0, pulse_addr[0], pulse_data[0]}, 32'h1280);

`ifdef OV7670_CFG_TIMEOUT_EN
    // Master never re-raises ready after the first write
    stuck_mode = 1'b1;
    reset_models();
    pulse_start();
    wait_done("t", 500);
    check_eq("t_error", {31'd0, error}, 32'd1);
    check_eq("t_pulses", pulse_cnt, 32'd1);
    stuck_mode = 1'b0;
    reset_models();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    check_eq("t_restart_error_clr", {31'd0, error}, 32'd0);
    check_eq("t_restart_done_clr", {31'd0, done}, 32'd0);
    wait_done("t2", 2000);
    check_eq("t2_error", {31'd0, error}, 32'd0);
    check_eq("t2_pulses", pulse_cnt, 32'd2);
`endif

    // Asynchronous reset in the middle of a delay entry
    load_term();
    rom_mem[0] = 16'hFFF0; rom_mem[1] = 16'h1280;
    ack_cycles = 2;
    reset_models();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("r_busy_in_delay", {31'd0, busy}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("r_busy", {31'd0, busy}, 32'd0);
    check_eq("r_done_error", {30'd0, done, error}, 32'd0);
    check_eq("r_sccb_start", {31'd0, sccb_start}, 32'd0);
    check_eq("r_rom_addr", {24'd0, rom_addr}, 32'd0);
    check_eq("r_sccb_addr_data", {16'd0, sccb_addr, sccb_data}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    reset_models();
    pulse_start();
    wait_done("r", 2000);
    check_eq("r_pulses", pulse_cnt, 32'd1);
    check_eq("r_w0", {16'd0, pulse_addr[0], pulse_data[0]}, 32'h1280);
    check_eq("r_end_rom_addr", {24'd0, rom_addr}, 32'd2);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
